// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer_if
// Description : FIFO read port, flush request and packed output stream of
//               fifo_word_packer, grouped for the packer and its peers.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_word_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) ();
    logic                     fifo_rd_en;
    logic [WIDTH-1:0]         fifo_rd_data;
    logic                     fifo_empty;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*RATIO-1:0]   out_data;
    logic [RATIO-1:0]         out_keep;
    logic                     out_last;

    // The packer side
    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        input  flush,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_keep,
        output out_last
    );

    // The FIFO / downstream side
    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        output flush,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_keep,
        input  out_last
    );
endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer
// Description : Pops WIDTH-bit words from a synchronous FIFO, packs RATIO of
//               them into one beat behind a one-beat valid/ready register;
//               flush closes a partial beat with keep mask and last.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fifo_word_packer_if.master    bus
);
    localparam int c_cnt_w = $clog2(RATIO + 1);
    localparam logic [c_cnt_w-1:0] c_ratio_cnt = c_cnt_w'(RATIO);
    localparam logic [c_cnt_w:0]   c_ratio_ext = (c_cnt_w + 1)'(RATIO);

    localparam logic [1:0] c_st_fill       = 2'd0;
    localparam logic [1:0] c_st_flush_wait = 2'd1;
    localparam logic [1:0] c_st_flush_emit = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_cnt_cap;
    logic                     r_inflight;
    logic [c_cnt_w:0]         w_sum;
    logic [WIDTH*RATIO-1:0]   r_acc;
    logic [WIDTH*RATIO-1:0]   w_acc_cap;
    logic [WIDTH*RATIO-1:0]   w_part_data;
    logic [RATIO-1:0]         w_part_keep;
    logic                     w_free;
    logic                     w_full;
    logic                     w_rd_en;
    logic                     w_load_full;
    logic                     w_load_part;
    logic                     w_last_full;

    logic                     r_out_valid;
    logic [WIDTH*RATIO-1:0]   r_out_data;
    logic [RATIO-1:0]         r_out_keep;
    logic                     r_out_last;

    // w_cnt_cap is the word count once any in-flight word lands this edge
    assign w_sum     = {1'b0, r_cnt} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_cnt_cap = r_cnt + {{(c_cnt_w-1){1'b0}}, r_inflight};
    assign w_full    = (w_cnt_cap == c_ratio_cnt);
    assign w_free    = !r_out_valid || bus.out_ready;

    generate
        for (genvar i = 0; i < RATIO; i++) begin : g_lane
            localparam logic [c_cnt_w-1:0] c_idx = c_cnt_w'(i);
            assign w_acc_cap[i*WIDTH +: WIDTH] = (r_inflight && (r_cnt == c_idx))
                                               ? bus.fifo_rd_data
                                               : r_acc[i*WIDTH +: WIDTH];
            assign w_part_keep[i] = (c_idx < r_cnt);
            assign w_part_data[i*WIDTH +: WIDTH] = w_part_keep[i]
                                                 ? r_acc[i*WIDTH +: WIDTH]
                                                 : {WIDTH{1'b0}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_fill: begin
                if (bus.flush) begin
                    w_state_next = c_st_flush_wait;
                end
            end
            // No pops here, so any in-flight word retires at this very edge
            c_st_flush_wait: begin
                w_state_next = c_st_flush_emit;
            end
            c_st_flush_emit: begin
                if ((r_cnt == '0) || w_free) begin
                    w_state_next = c_st_fill;
                end
            end
            default: begin
                w_state_next = c_st_fill;
            end
        endcase
    end

    always_comb begin
        w_rd_en     = !rst && !bus.fifo_empty && (r_state == c_st_fill)
                      && (w_sum < c_ratio_ext);
        w_load_full = w_full && w_free;
        // A full beat loaded while a flush is open is the last of the data
        w_last_full = (r_state != c_st_fill) || bus.flush;
        w_load_part = (r_state == c_st_flush_emit) && (r_cnt != '0)
                      && !w_full && w_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_inflight  <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_acc      <= w_acc_cap;
            if (w_load_full || w_load_part) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_cap;
            end

            if (w_load_full) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_cap;
                r_out_keep  <= '1;
                r_out_last  <= w_last_full;
            end else if (w_load_part) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_part_data;
                r_out_keep  <= w_part_keep;
                r_out_last  <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_keep   = r_out_keep;
    assign bus.out_last   = r_out_last;

endmodule
`default_nettype wire
